// File: rtl/dl_shift_pkg.sv
// rtl/dl_shift_pkg.sv - shared types for the multi-cycle shift sequencer
// Shift opcodes and sequencer FSM states.
package dl_shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'd0,
      SHIFT_SRL  = 2'd1,
      SHIFT_SRA  = 2'd2,
      SHIFT_RSVD = 2'd3
   } shift_op_t;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_BUSY = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_t;

   // Width of a step count able to hold 0..max_step inclusive.
   function automatic int step_width(input int max_step);
      return $clog2(max_step + 1);
   endfunction

endpackage

// File: rtl/dl_shift_step.sv
// rtl/dl_shift_step.sv - combinational narrow shifter, 0..MAX_STEP bits per op
// The reserved opcode executes as SLL.
module dl_shift_step
   import dl_shift_pkg::*;
#(
   parameter int NUM_BITS = 8,
   parameter int MAX_STEP = 2,
   parameter int SW       = step_width(MAX_STEP)
) (
   input  logic [NUM_BITS-1:0] data,
   input  logic [1:0]          op,
   input  logic [SW-1:0]       step,
   output logic [NUM_BITS-1:0] result
);

   always_comb begin
      result = data << step;
      case (op)
         SHIFT_SRL: result = data >> step;
         SHIFT_SRA: result = NUM_BITS'($signed(data) >>> step);
         default:   result = data << step;
      endcase
   end

endmodule

// File: rtl/dl_shift_seq.sv
// rtl/dl_shift_seq.sv - multi-cycle SLL/SRL/SRA sequencer, one op in flight
// Optional early completion on fill pattern: DL_SHIFT_SEQ_EARLY_DONE_EN.
module dl_shift_seq
   import dl_shift_pkg::*;
#(
   parameter int NUM_BITS = 8,
   parameter int MAX_STEP = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_BITS-1:0]         in_data,
   input  logic [$clog2(NUM_BITS)-1:0] in_shamt,
   input  logic [1:0]                  in_op,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_BITS-1:0]         out_data,
   output logic                        busy
);

   localparam int AW = $clog2(NUM_BITS);
   localparam int SW = step_width(MAX_STEP);

   seq_state_t          state;
   logic [NUM_BITS-1:0] work;
   logic [AW-1:0]       rem;
   shift_op_t           op;

   logic [SW-1:0]       step;
   logic [AW-1:0]       rem_next;
   logic [NUM_BITS-1:0] work_next;
   logic                early_accept;
   logic                early_busy;

   // step never exceeds rem, so rem cannot underflow
   always_comb begin
      if (rem < AW'(MAX_STEP)) begin
         step = SW'(rem);
      end else begin
         step = SW'(MAX_STEP);
      end
      rem_next = rem - AW'(step);
   end

   dl_shift_step #(
      .NUM_BITS (NUM_BITS),
      .MAX_STEP (MAX_STEP),
      .SW       (SW)
   ) u_step (
      .data   (work),
      .op     (op),
      .step   (step),
      .result (work_next)
   );

`ifdef DL_SHIFT_SEQ_EARLY_DONE_EN
   logic [NUM_BITS-1:0] fill_in;
   logic [NUM_BITS-1:0] fill_work;

   // Once the operand equals its fill pattern, further shifting cannot change it.
   always_comb begin
      fill_in   = (in_op == SHIFT_SRA) ? {NUM_BITS{in_data[NUM_BITS-1]}} : '0;
      fill_work = (op == SHIFT_SRA) ? {NUM_BITS{work[NUM_BITS-1]}} : '0;
   end

   assign early_accept = (in_data == fill_in);
   assign early_busy   = (work_next == fill_work);
`else
   assign early_accept = 1'b0;
   assign early_busy   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEQ_IDLE;
         work  <= '0;
         rem   <= '0;
         op    <= SHIFT_SLL;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (in_valid) begin
                  work <= in_data;
                  rem  <= in_shamt;
                  op   <= shift_op_t'(in_op);
                  if (in_shamt == '0 || early_accept) begin
                     state <= SEQ_DONE;
                  end else begin
                     state <= SEQ_BUSY;
                  end
               end
            end
            SEQ_BUSY: begin
               work <= work_next;
               rem  <= rem_next;
               if (rem_next == '0 || early_busy) begin
                  state <= SEQ_DONE;
               end
            end
            SEQ_DONE: begin
               if (out_ready) begin
                  state <= SEQ_IDLE;
               end
            end
            default: state <= SEQ_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == SEQ_IDLE);
   assign out_valid = (state == SEQ_DONE);
   assign busy      = (state != SEQ_IDLE);
   assign out_data  = work;

endmodule

// File: tb/tb_dl_shift_seq.sv
// tb/tb_dl_shift_seq.sv - self-checking bench for dl_shift_seq (NUM_BITS=8, MAX_STEP=2)
// Expected results come from plain arithmetic shifts; latency from the step-count rule.
module tb_dl_shift_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_shamt;
   logic [1:0] in_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   int tests;
   int fails;

   dl_shift_seq #(.NUM_BITS(8), .MAX_STEP(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] o);
      logic signed [7:0] sd;
      int v;
      sd = d;
      case (o)
         2'd1: v = int'(d) / (1 << s);
         2'd2: return 8'(sd >>> s);
         default: v = (int'(d) * (1 << s)) % 256;
      endcase
      return 8'(v);
   endfunction

   function automatic int ref_lat(input logic [7:0] d, input int s, input logic [1:0] o);
`ifdef DL_SHIFT_SEQ_EARLY_DONE_EN
      logic [7:0] fill;
      logic [7:0] v;
      int r;
      int n;
      int st;
      if (s == 0) return 1;
      fill = (o == 2'd2 && d[7]) ? 8'hFF : 8'h00;
      if (d == fill) return 1;
      v = d;
      r = s;
      n = 1;
      while (r > 0) begin
         st = (r < 2) ? r : 2;
         v = ref_shift(v, st, o);
         r = r - st;
         n++;
         if (v == fill) break;
      end
      return n;
`else
      return 1 + (s + 1) / 2;
`endif
   endfunction

   task automatic do_op(input logic [7:0] d, input logic [2:0] s, input logic [1:0] o,
                        output int lat, output logic [7:0] res, output logic busy_ok);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_op    = o;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_shamt = 3'($urandom);
      lat      = 1;
      busy_ok  = 1'b1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!busy) busy_ok = 1'b0;
      res = out_data;
   endtask

   task automatic finish_op();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 00 0",
                  in_ready, out_valid, out_data, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      int lat;
      logic [7:0] res;
      logic bok;
      do_op(8'h81, 3'd3, 2'd0, lat, res, bok);
      tests++;
      if (res !== 8'h08 || lat !== ref_lat(8'h81, 3, 2'd0) || bok !== 1'b1) begin
         fails++;
         $display("FAIL sll_81_3: data=%h lat=%0d busy_ok=%b, want 08 %0d 1", res, lat, bok, ref_lat(8'h81, 3, 2'd0));
      end
      finish_op();
      do_op(8'h90, 3'd5, 2'd2, lat, res, bok);
      tests++;
      if (res !== 8'hFC || lat !== ref_lat(8'h90, 5, 2'd2)) begin
         fails++;
         $display("FAIL sra_90_5: data=%h lat=%0d, want fc %0d", res, lat, ref_lat(8'h90, 5, 2'd2));
      end
      finish_op();
      do_op(8'h90, 3'd5, 2'd1, lat, res, bok);
      tests++;
      if (res !== 8'h04 || lat !== ref_lat(8'h90, 5, 2'd1)) begin
         fails++;
         $display("FAIL srl_90_5: data=%h lat=%0d, want 04 %0d", res, lat, ref_lat(8'h90, 5, 2'd1));
      end
      finish_op();
      do_op(8'h5A, 3'd0, 2'd1, lat, res, bok);
      tests++;
      if (res !== 8'h5A || lat !== 1) begin
         fails++;
         $display("FAIL shamt0: data=%h lat=%0d, want 5a 1", res, lat);
      end
      finish_op();
      do_op(8'h0F, 3'd2, 2'd3, lat, res, bok);
      tests++;
      if (res !== 8'h3C) begin
         fails++;
         $display("FAIL rsvd_as_sll: data=%h, want 3c", res);
      end
      finish_op();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [7:0] res;
      logic bok;
      logic ok;
      do_op(8'hC3, 3'd4, 2'd1, lat, res, bok);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = 8'(i * 37 + 1);
         in_shamt = 3'd1;
         in_op    = 2'd0;
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== 8'h0C || in_ready !== 1'b0) ok = 1'b0;
      end
      in_valid = 1'b0;
      tests++;
      if (!ok || res !== 8'h0C) begin
         fails++;
         $display("FAIL backpressure_hold: out_valid=%b out_data=%h in_ready=%b, want 1 0c 0",
                  out_valid, out_data, in_ready);
      end
      finish_op();
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h0C) begin
         fails++;
         $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 0c",
                  in_ready, out_valid, busy, out_data);
      end
   endtask

   task automatic test_reset_mid_busy();
      int lat;
      logic [7:0] res;
      logic bok;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_shamt = 3'd7;
      in_op    = 2'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 00 0",
                  in_ready, out_valid, out_data, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h80, 3'd1, 2'd1, lat, res, bok);
      tests++;
      if (res !== 8'h40 || lat !== 2) begin
         fails++;
         $display("FAIL after_reset_srl: data=%h lat=%0d, want 40 2", res, lat);
      end
      finish_op();
   endtask

   task automatic test_early_done();
      int lat;
      logic [7:0] res;
      logic bok;
      int exp_a;
      int exp_b;
`ifdef DL_SHIFT_SEQ_EARLY_DONE_EN
      exp_a = 2;
      exp_b = 1;
`else
      exp_a = 5;
      exp_b = 3;
`endif
      do_op(8'h01, 3'd7, 2'd1, lat, res, bok);
      tests++;
      if (res !== 8'h00 || lat !== exp_a) begin
         fails++;
         $display("FAIL early_srl_01_7: data=%h lat=%0d, want 00 %0d", res, lat, exp_a);
      end
      finish_op();
      do_op(8'hFF, 3'd4, 2'd2, lat, res, bok);
      tests++;
      if (res !== 8'hFF || lat !== exp_b) begin
         fails++;
         $display("FAIL early_sra_ff_4: data=%h lat=%0d, want ff %0d", res, lat, exp_b);
      end
      finish_op();
   endtask

   task automatic test_random();
      int lat;
      logic [7:0] res;
      logic bok;
      logic [7:0] d;
      logic [2:0] s;
      logic [1:0] o;
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         s = 3'($urandom);
         o = 2'($urandom);
         do_op(d, s, o, lat, res, bok);
         tests++;
         if (res !== ref_shift(d, int'(s), o) || lat !== ref_lat(d, int'(s), o) || bok !== 1'b1) begin
            fails++;
            $display("FAIL random[%0d] d=%h s=%0d op=%0d: data=%h lat=%0d busy_ok=%b, want %h %0d 1",
                     i, d, s, o, res, lat, bok, ref_shift(d, int'(s), o), ref_lat(d, int'(s), o));
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         finish_op();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [7:0] res;
      logic bok;
      do_op(8'h33, 3'd2, 2'd0, lat, res, bok);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      in_shamt  = 3'd3;
      in_op     = 2'd2;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'hCC) begin
         fails++;
         $display("FAIL b2b_no_handoff: in_ready=%b busy=%b out_data=%h, want 1 0 cc", in_ready, busy, out_data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      tests++;
      if (out_data !== 8'hF4 || lat !== ref_lat(8'hA5, 3, 2'd2)) begin
         fails++;
         $display("FAIL b2b_second: data=%h lat=%0d, want f4 %0d", out_data, lat, ref_lat(8'hA5, 3, 2'd2));
      end
      finish_op();
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_shamt  = 3'd0;
      in_op     = 2'd0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_busy();
      test_early_done();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
